// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: ALU operation codes, base opcodes, forwarding
// select encodings, operand-select enums and the decoded-control payload.
// Used by the ID/EX stage, its decoder and the ALU.
package cpu_pkg;

  localparam int unsigned NB_ALU_OP = 4;
  localparam int unsigned NB_OPCODE = 7;
  localparam int unsigned NB_FUNCT3 = 3;
  localparam int unsigned NB_FWD    = 2;

  typedef enum logic [NB_ALU_OP-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [NB_OPCODE-1:0] OPC_OP     = 7'b0110011;
  localparam logic [NB_OPCODE-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [NB_OPCODE-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [NB_OPCODE-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [NB_OPCODE-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [NB_OPCODE-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [NB_OPCODE-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [NB_OPCODE-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [NB_OPCODE-1:0] OPC_BRANCH = 7'b1100011;

  // Forwarding select; 0 and 3 both mean "use the register file value".
  localparam logic [NB_FWD-1:0] FWD_NONE   = 2'd0;
  localparam logic [NB_FWD-1:0] FWD_EX_MEM = 2'd1;
  localparam logic [NB_FWD-1:0] FWD_MEM_WB = 2'd2;
  localparam logic [NB_FWD-1:0] FWD_NONE2  = 2'd3;

  // Encoding 0 of both selects must pick the (cleared) register operand so
  // that a reset/flushed stage drives zero operands.
  typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} op_a_sel_e;
  typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2} op_b_sel_e;

  typedef struct packed {
    alu_op_e   alu_op;
    op_a_sel_e a_sel;
    op_b_sel_e b_sel;
    logic      reg_write;
    logic      illegal;
  } dec_t;

  // Register/immediate arithmetic mapping; alt selects SUB/SRA.
  function automatic alu_op_e arith_op(input logic [NB_FUNCT3-1:0] funct3,
                                       input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (funct3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational decode of opcode/funct3/funct7[5] into ALU operation,
// operand-A/B selects, register-write enable and illegal-opcode flag.
// Ports: opcode, funct3, funct7_b5 in; dec (dec_t payload) out.
module alu_op_decoder
  import cpu_pkg::*;
(
  input  logic [NB_OPCODE-1:0] opcode,
  input  logic [NB_FUNCT3-1:0] funct3,
  input  logic                 funct7_b5,
  output dec_t                 dec
);

  always_comb begin
    dec.alu_op    = ALU_ADD;
    dec.a_sel     = A_RS1;
    dec.b_sel     = B_RS2;
    dec.reg_write = 1'b0;
    dec.illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.alu_op    = arith_op(funct3, funct7_b5);
        dec.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        // funct7[5] is immediate data for ADDI, so only shifts honour it.
        dec.alu_op    = arith_op(funct3, funct7_b5 && (funct3 == 3'b101));
        dec.b_sel     = B_IMM;
        dec.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        dec.b_sel     = B_IMM;
        dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec.b_sel     = B_IMM;
      end
      OPC_LUI: begin
        dec.a_sel     = A_ZERO;
        dec.b_sel     = B_IMM;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a_sel     = A_PC;
        dec.b_sel     = B_IMM;
        dec.reg_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec.a_sel     = A_PC;
        dec.b_sel     = B_FOUR;
        dec.reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        // Equality via zero flag of SUB; ordering via set-less-than.
        case (funct3[2:1])
          2'b00:   dec.alu_op = ALU_SUB;
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: dec.alu_op = ALU_ADD;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register ahead of the ALU. Registers decoded control and
// operands, then forwards and selects the two ALU operands combinationally.
// Inputs: i_clk, i_rst_n (sync, active-low), i_valid, i_stall, i_flush,
//   instruction fields, i_pc, i_rs1_data/i_rs2_data, i_imm, i_rd_addr,
//   forwarding selects and data.
// Outputs: o_data1/o_data2 ALU operands, o_alu_op, o_store_data, o_pc,
//   o_rd_addr, o_reg_write, o_valid, o_illegal.
// Build option: define ID_EX_FWD_EN to enable EX/MEM and MEM/WB forwarding.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_REG  = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [NB_OPCODE-1:0] i_opcode,
  input  logic [NB_FUNCT3-1:0] i_funct3,
  input  logic                 i_funct7_b5,
  input  logic [NB_DATA-1:0]   i_pc,
  input  logic [NB_DATA-1:0]   i_rs1_data,
  input  logic [NB_DATA-1:0]   i_rs2_data,
  input  logic [NB_DATA-1:0]   i_imm,
  input  logic [NB_REG-1:0]    i_rd_addr,
  input  logic [NB_FWD-1:0]    i_fwd_a_sel,
  input  logic [NB_FWD-1:0]    i_fwd_b_sel,
  input  logic [NB_DATA-1:0]   i_ex_mem_data,
  input  logic [NB_DATA-1:0]   i_mem_wb_data,
  output logic [NB_DATA-1:0]   o_data1,
  output logic [NB_DATA-1:0]   o_data2,
  output logic [NB_ALU_OP-1:0] o_alu_op,
  output logic [NB_DATA-1:0]   o_store_data,
  output logic [NB_DATA-1:0]   o_pc,
  output logic [NB_REG-1:0]    o_rd_addr,
  output logic                 o_reg_write,
  output logic                 o_valid,
  output logic                 o_illegal
);

  dec_t                dec;
  dec_t                dec_q;
  logic                valid_q;
  logic [NB_DATA-1:0]  pc_q;
  logic [NB_DATA-1:0]  rs1_q;
  logic [NB_DATA-1:0]  rs2_q;
  logic [NB_DATA-1:0]  imm_q;
  logic [NB_REG-1:0]   rd_q;
  logic [NB_DATA-1:0]  rs1_fwd;
  logic [NB_DATA-1:0]  rs2_fwd;

  alu_op_decoder u_dec (
    .opcode    (i_opcode),
    .funct3    (i_funct3),
    .funct7_b5 (i_funct7_b5),
    .dec       (dec)
  );

  // Stage register: reset and flush both clear, stall holds.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      dec_q   <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
    end else if (!i_stall) begin
      dec_q.alu_op    <= dec.alu_op;
      dec_q.a_sel     <= dec.a_sel;
      dec_q.b_sel     <= dec.b_sel;
      dec_q.reg_write <= dec.reg_write & i_valid;
      dec_q.illegal   <= dec.illegal & i_valid;
      valid_q         <= i_valid;
      pc_q            <= i_pc;
      rs1_q           <= i_rs1_data;
      rs2_q           <= i_rs2_data;
      imm_q           <= i_imm;
      rd_q            <= i_rd_addr;
    end
  end

`ifdef ID_EX_FWD_EN
  // Forwarding on the held register values; live in the same cycle.
  always_comb begin
    rs1_fwd = rs1_q;
    rs2_fwd = rs2_q;
    case (i_fwd_a_sel)
      FWD_EX_MEM: rs1_fwd = i_ex_mem_data;
      FWD_MEM_WB: rs1_fwd = i_mem_wb_data;
      default:    rs1_fwd = rs1_q;
    endcase
    case (i_fwd_b_sel)
      FWD_EX_MEM: rs2_fwd = i_ex_mem_data;
      FWD_MEM_WB: rs2_fwd = i_mem_wb_data;
      default:    rs2_fwd = rs2_q;
    endcase
  end
`else
  // Forwarding ports are kept for a uniform interface but have no effect.
  logic unused_fwd;
  assign unused_fwd = ^{i_fwd_a_sel, i_fwd_b_sel, i_ex_mem_data, i_mem_wb_data};
  assign rs1_fwd    = rs1_q;
  assign rs2_fwd    = rs2_q;
`endif

  // Operand selection after forwarding.
  always_comb begin
    o_data1 = rs1_fwd;
    o_data2 = rs2_fwd;
    case (dec_q.a_sel)
      A_PC:    o_data1 = pc_q;
      A_ZERO:  o_data1 = '0;
      default: o_data1 = rs1_fwd;
    endcase
    case (dec_q.b_sel)
      B_IMM:   o_data2 = imm_q;
      B_FOUR:  o_data2 = NB_DATA'(4);
      default: o_data2 = rs2_fwd;
    endcase
  end

  assign o_alu_op     = dec_q.alu_op;
  assign o_store_data = rs2_fwd;
  assign o_pc         = pc_q;
  assign o_rd_addr    = rd_q;
  assign o_reg_write  = dec_q.reg_write;
  assign o_valid      = valid_q;
  assign o_illegal    = dec_q.illegal;

endmodule
